lsu_seq: RTL and testbench



---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_if.sv | 40 ++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
//   - memop encodings seen on the core request port
//   - sequencer state enum
//   - size_of():    access size in bytes (1, 2 or 4) for a memop
//   - is_illegal(): flags the unused memop encodings 011, 100, 111
package lsu_pkg;

    localparam logic [2:0] MEMOP_WORD = 3'b000;
    localparam logic [2:0] MEMOP_BU   = 3'b001;
    localparam logic [2:0] MEMOP_HU   = 3'b010;
    localparam logic [2:0] MEMOP_BS   = 3'b101;
    localparam logic [2:0] MEMOP_HS   = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        ADDR0,
        DATA0,
        ADDR1,
        DATA1,
        WRITE0,
        WRITE1,
        RESP
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] memop);
        case (memop)
            MEMOP_BU, MEMOP_BS: return 3'd1;
            MEMOP_HU, MEMOP_HS: return 3'd2;
            default:            return 3'd4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] memop);
        return (memop == 3'b011) || (memop == 3'b100) || (memop == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response handshake plus the word-wide memory bus.
//   slave  modport: the sequencer (consumes requests, drives the memory bus)
//   master modport: the environment (core issuing requests + data memory)
// Signals:
//   req_valid/req_ready/req_we/req_memop/req_addr/req_wdata  request channel
//   rsp_valid/rsp_rdata/rsp_err                              response pulse
//   mem_addr/mem_we/mem_memop/mem_wdata/mem_rdata            memory bus
//   busy                                                     ~req_ready
interface lsu_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_memop;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [2:0]        mem_memop;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_we, mem_memop, mem_wdata, busy
    );

    modport master (
        output req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_we, mem_memop, mem_wdata, busy
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the sequencer.
//   Extract: {w1, w0} >> 8*offset, then zero/sign-extend per memop -> load_data
//   Merge:   replace the store lanes of {w1, w0} with wdata -> merged_w0/merged_w1
// Ports:
//   w0, w1     in  words at word0 and word0+4 (little-endian lanes)
//   offset     in  byte offset of the access within word0
//   memop      in  access memop (size for stores, size+extension for loads)
//   wdata      in  right-justified store data
//   load_data  out extended load result
//   merged_w0  out w0 with store lanes replaced
//   merged_w1  out w1 with store lanes replaced (split accesses only)
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [1:0]        offset,
    input  logic [2:0]        memop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged_w0,
    output logic [DATA_W-1:0] merged_w1
);
    logic [4:0]          shamt;
    logic [2*DATA_W-1:0] pair;
    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   lane_mask;
    logic [2*DATA_W-1:0] mask64;
    logic [2*DATA_W-1:0] data64;
    logic [2*DATA_W-1:0] merged;

    always_comb begin
        shamt   = {offset, 3'b000};
        pair    = {w1, w0};
        shifted = pair >> shamt;
        raw     = shifted[DATA_W-1:0];

        case (memop)
            MEMOP_BU: load_data = {{(DATA_W-8){1'b0}},  raw[7:0]};
            MEMOP_HU: load_data = {{(DATA_W-16){1'b0}}, raw[15:0]};
            MEMOP_BS: load_data = {{(DATA_W-8){raw[7]}},   raw[7:0]};
            MEMOP_HS: load_data = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            default:  load_data = raw;
        endcase

        case (size_of(memop))
            3'd1:    lane_mask = {{(DATA_W-8){1'b0}},  8'hFF};
            3'd2:    lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            default: lane_mask = '1;
        endcase

        // Mask and data are placed in a 64-bit window so a split store
        // spills its upper lanes naturally into w1.
        mask64    = {{DATA_W{1'b0}}, lane_mask} << shamt;
        data64    = {{DATA_W{1'b0}}, wdata & lane_mask} << shamt;
        merged    = (pair & ~mask64) | data64;
        merged_w0 = merged[DATA_W-1:0];
        merged_w1 = merged[2*DATA_W-1:DATA_W];
    end
endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: multi-cycle load/store sequencer in front of a word-wide memory.
// Every request becomes whole-word memory cycles (mem_memop fixed 3'b000);
// sub-word stores are read-modify-write, sub-word loads are extracted and
// extended locally. One response pulse per request.
// Ports:
//   clk   in  system clock, rising edge
//   rstn  in  asynchronous active-low reset
//   bus   lsu_if.slave: request/response handshake and memory bus
// Configuration macro: LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned half/word accesses are serviced, splitting across
//               two words when they cross a word boundary
//   undefined - misaligned accesses respond with err = 1 and no memory cycle
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rstn,
    lsu_if.slave bus
);
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        memop_q, memop_d;
    logic [ADDR_W-1:0] word0_q, word0_d;
    logic [1:0]        offset_q, offset_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] w0_q, w0_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]        req_size;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_word0;
    logic              req_misal;

    logic [DATA_W-1:0] eff_w0, eff_w1;
    logic [DATA_W-1:0] load_data, merged_w0, merged_w1;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q, split_d;
    logic [DATA_W-1:0] w1_q, w1_d;
`else
    logic              unused_w1;
    assign unused_w1 = ^merged_w1;
`endif

    // The word being captured this cycle is taken straight from mem_rdata so
    // the merged write word / load result can be registered on the same edge.
    always_comb begin
        eff_w0 = (state_q == DATA0) ? bus.mem_rdata : w0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        eff_w1 = (state_q == DATA1) ? bus.mem_rdata : w1_q;
`else
        eff_w1 = '0;
`endif
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .w0        (eff_w0),
        .w1        (eff_w1),
        .offset    (offset_q),
        .memop     (memop_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged_w0 (merged_w0),
        .merged_w1 (merged_w1)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        memop_d     = memop_q;
        word0_d     = word0_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        w0_d        = w0_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d     = split_q;
        w1_d        = w1_q;
`endif
        req_size  = size_of(bus.req_memop);
        req_off   = bus.req_addr[1:0];
        req_word0 = {bus.req_addr[ADDR_W-1:2], 2'b00};
        req_misal = ((req_size == 3'd2) && req_off[0]) ||
                    ((req_size == 3'd4) && (req_off != 2'd0));

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    memop_d  = bus.req_memop;
                    word0_d  = req_word0;
                    offset_d = req_off;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d  = (({1'b0, req_off} + req_size) > 3'd4);
                    if (is_illegal(bus.req_memop)) begin
`else
                    if (is_illegal(bus.req_memop) || req_misal) begin
`endif
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (bus.req_we && !req_misal && (req_size == 3'd4)) begin
                        mem_addr_d  = req_word0;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                        state_d     = WRITE0;
                    end else begin
                        mem_addr_d = req_word0;
                        state_d    = ADDR0;
                    end
                end
            end
            ADDR0: state_d = DATA0;
            DATA0: begin
                w0_d = bus.mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    mem_addr_d = word0_q + ADDR_W'(4);
                    state_d    = ADDR1;
                end else
`endif
                if (we_q) begin
                    mem_addr_d  = word0_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_w0;
                    state_d     = WRITE0;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ADDR1: state_d = DATA1;
            DATA1: begin
                w1_d = bus.mem_rdata;
                if (we_q) begin
                    mem_addr_d  = word0_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_w0;
                    state_d     = WRITE0;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            WRITE0: begin
                if (split_q) begin
                    mem_addr_d  = word0_q + ADDR_W'(4);
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_w1;
                    state_d     = WRITE1;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE1: state_d = RESP;
`else
            WRITE0: state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            memop_q     <= '0;
            word0_q     <= '0;
            offset_q    <= '0;
            wdata_q     <= '0;
            w0_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            w1_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            memop_q     <= memop_d;
            word0_q     <= word0_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            w0_q        <= w0_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            w1_q        <= w1_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_memop = MEMOP_WORD;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_seq.sv
module tb_lsu_seq;
    logic clk;
    logic rstn;

    lsu_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    lsu_seq #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory: registered read, write on the falling edge.
    logic [31:0] mem [0:16383];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr[15:2]];
    always @(negedge clk) if (bus.mem_we) mem[bus.mem_addr[15:2]] <= bus.mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the last transaction
    int          res_lat;
    logic [31:0] res_rdata;
    logic        res_err;
    int          res_nwe;
    int          res_nrd;
    logic [15:0] res_we_addr [4];
    logic [15:0] res_rd_addr [8];

    task automatic run_req(input logic we, input logic [2:0] op,
                           input logic [15:0] addr, input logic [31:0] wd);
        bit got;
        int cyc;
        @(negedge clk);
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_memop = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        got = 0; cyc = 0; res_nwe = 0; res_nrd = 0;
        res_rdata = 'x; res_err = 1'bx; res_lat = -1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("ready_low_busy", {31'b0, bus.req_ready}, 32'd0);
            if (bus.mem_we) begin
                if (res_nwe < 4) res_we_addr[res_nwe] = bus.mem_addr;
                res_nwe++;
            end else if (bus.busy && !bus.rsp_valid) begin
                if (res_nrd < 8) res_rd_addr[res_nrd] = bus.mem_addr;
                res_nrd++;
            end
            if (bus.rsp_valid) begin
                got       = 1;
                res_lat   = cyc;
                res_rdata = bus.rsp_rdata;
                res_err   = bus.rsp_err;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    logic [2:0]  ld_op  [7];
    logic [15:0] ld_adr [7];
    logic [31:0] ld_exp [7];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        mem[0]     = 32'h88776655;
        mem[8]     = 32'h11223344;
        mem[9]     = 32'h55667788;
        mem[16383] = 32'hDDCCBBAA;

        ld_op[0] = 3'b101; ld_adr[0] = 16'h0002; ld_exp[0] = 32'h00000077;
        ld_op[1] = 3'b101; ld_adr[1] = 16'h0003; ld_exp[1] = 32'hFFFFFF88;
        ld_op[2] = 3'b110; ld_adr[2] = 16'h0002; ld_exp[2] = 32'hFFFF8877;
        ld_op[3] = 3'b110; ld_adr[3] = 16'h0000; ld_exp[3] = 32'h00006655;
        ld_op[4] = 3'b001; ld_adr[4] = 16'h0003; ld_exp[4] = 32'h00000088;
        ld_op[5] = 3'b010; ld_adr[5] = 16'h0002; ld_exp[5] = 32'h00008877;
        ld_op[6] = 3'b000; ld_adr[6] = 16'h0000; ld_exp[6] = 32'h88776655;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_memop = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rstn = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_busy",      {31'b0, bus.busy},      32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
        check("rst_mem_we",    {31'b0, bus.mem_we},    32'd0);
        check("rst_mem_addr",  {16'b0, bus.mem_addr},  32'd0);
        check("rst_mem_memop", {29'b0, bus.mem_memop}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Aligned sub-word and word loads
        for (int i = 0; i < 7; i++) begin
            run_req(1'b0, ld_op[i], ld_adr[i], 32'h0);
            check("ld_rdata", res_rdata, ld_exp[i]);
            check("ld_err",   {31'b0, res_err}, 32'd0);
            check("ld_lat",   res_lat, 32'd3);
            check("ld_nwe",   res_nwe, 32'd0);
        end
        check("ld_nrd", res_nrd, 32'd2);

        // Aligned word store: straight to write, no read
        run_req(1'b1, 3'b000, 16'h0010, 32'h12345678);
        check("sw_lat",    res_lat, 32'd2);
        check("sw_nwe",    res_nwe, 32'd1);
        check("sw_nrd",    res_nrd, 32'd0);
        check("sw_addr",   {16'b0, res_we_addr[0]}, 32'h0010);
        check("sw_rdata",  res_rdata, 32'd0);
        check("sw_err",    {31'b0, res_err}, 32'd0);
        check("sw_mem",    mem[4], 32'h12345678);

        // Illegal memop, then a normal request
        run_req(1'b0, 3'b011, 16'h0010, 32'h0);
        check("ill_err",   {31'b0, res_err}, 32'd1);
        check("ill_lat",   res_lat, 32'd1);
        check("ill_nrd",   res_nrd, 32'd0);
        check("ill_nwe",   res_nwe, 32'd0);
        check("ill_rdata", res_rdata, 32'd0);
        run_req(1'b1, 3'b111, 16'h0010, 32'hFFFFFFFF);
        check("ill_st_err", {31'b0, res_err}, 32'd1);
        check("ill_st_nwe", res_nwe, 32'd0);
        check("ill_st_mem", mem[4], 32'h12345678);
        run_req(1'b0, 3'b000, 16'h0010, 32'h0);
        check("post_ill_rdata", res_rdata, 32'h12345678);
        check("post_ill_err",   {31'b0, res_err}, 32'd0);

        // Byte store (memop 101 used as store: size only), upper wdata bits ignored
        run_req(1'b1, 3'b101, 16'h0023, 32'hFFFFFFEE);
        check("sb_lat",   res_lat, 32'd4);
        check("sb_nwe",   res_nwe, 32'd1);
        check("sb_nrd",   res_nrd, 32'd2);
        check("sb_mem",   mem[8], 32'hEE223344);
        check("sb_rdata", res_rdata, 32'd0);

        // Half store at offset 1
        run_req(1'b1, 3'b010, 16'h0001, 32'h0000ABCD);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("sh1_err", {31'b0, res_err}, 32'd0);
        check("sh1_lat", res_lat, 32'd4);
        check("sh1_nwe", res_nwe, 32'd1);
        check("sh1_nrd", res_nrd, 32'd2);
        check("sh1_mem", mem[0], 32'h88ABCD55);
`else
        check("sh1_err", {31'b0, res_err}, 32'd1);
        check("sh1_lat", res_lat, 32'd1);
        check("sh1_nwe", res_nwe, 32'd0);
        check("sh1_mem", mem[0], 32'h88776655);
`endif

        // Half store at offset 3 (crosses into next word)
        run_req(1'b1, 3'b110, 16'h0023, 32'h0000BEEF);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("shs_err",   {31'b0, res_err}, 32'd0);
        check("shs_lat",   res_lat, 32'd7);
        check("shs_nwe",   res_nwe, 32'd2);
        check("shs_wa0",   {16'b0, res_we_addr[0]}, 32'h0020);
        check("shs_wa1",   {16'b0, res_we_addr[1]}, 32'h0024);
        check("shs_mem0",  mem[8], 32'hEF223344);
        check("shs_mem1",  mem[9], 32'h556677BE);
`else
        check("shs_err",   {31'b0, res_err}, 32'd1);
        check("shs_nwe",   res_nwe, 32'd0);
        check("shs_mem0",  mem[8], 32'hEE223344);
`endif

        // Misaligned word load at 0xFFFE (wraps to 0x0000 for the second word)
        mem[0] = 32'h44332211;
        run_req(1'b0, 3'b000, 16'hFFFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("spl_rdata", res_rdata, 32'h2211DDCC);
        check("spl_err",   {31'b0, res_err}, 32'd0);
        check("spl_lat",   res_lat, 32'd5);
        check("spl_nrd",   res_nrd, 32'd4);
        check("spl_ra0",   {16'b0, res_rd_addr[0]}, 32'hFFFC);
        check("spl_ra2",   {16'b0, res_rd_addr[2]}, 32'h0000);
`else
        check("spl_rdata", res_rdata, 32'd0);
        check("spl_err",   {31'b0, res_err}, 32'd1);
        check("spl_lat",   res_lat, 32'd1);
        check("spl_nrd",   res_nrd, 32'd0);
`endif

        // Reset during DATA0 of a load
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_memop = 3'b000;
        bus.req_addr  = 16'h0020;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy",     {31'b0, bus.busy},     32'd1);
        check("mid_mem_addr", {16'b0, bus.mem_addr}, 32'h0020);
        rstn = 1'b0;
        #1;
        check("ar_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("ar_busy",      {31'b0, bus.busy},      32'd0);
        check("ar_mem_addr",  {16'b0, bus.mem_addr},  32'd0);
        check("ar_mem_we",    {31'b0, bus.mem_we},    32'd0);
        check("ar_mem_wdata", bus.mem_wdata,          32'd0);
        check("ar_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("ar_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_req(1'b0, 3'b000, 16'h0010, 32'h0);
        check("post_rst_rdata", res_rdata, 32'h12345678);
        check("post_rst_lat",   res_lat, 32'd3);
        check("post_rst_err",   {31'b0, res_err}, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
